// File: rtl/mem_arbiter2.sv
`timescale 1ns/1ps
// mem_arbiter2: two-master round-robin arbiter in front of the shared external-memory port.
// The granted request is registered toward the slave, and in-order read responses are routed back through an owner-tag FIFO.
module mem_arbiter2 #(
   parameter int ADDR_W    = 30,
   parameter int DATA_W    = 32,
   parameter int ID_W      = 2,
   parameter int TAG_DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  rst_n,
   // master 0 (CPU)
   output logic                  m0_waitrequest,
   input  logic [ID_W-1:0]       m0_id,
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   input  logic [DATA_W/8-1:0]   m0_writedatamask,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic [ID_W-1:0]       m0_readdataid,
   // master 1 (display / DMA)
   output logic                  m1_waitrequest,
   input  logic [ID_W-1:0]       m1_id,
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   input  logic [DATA_W/8-1:0]   m1_writedatamask,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic [ID_W-1:0]       m1_readdataid,
   // slave (memory controller)
   input  logic                  s_waitrequest,
   output logic [ID_W-1:0]       s_id,
   output logic [ADDR_W-1:0]     s_address,
   output logic                  s_read,
   output logic                  s_write,
   output logic [DATA_W-1:0]     s_writedata,
   output logic [DATA_W/8-1:0]   s_writedatamask,
   input  logic [DATA_W-1:0]     s_readdata,
   input  logic [ID_W-1:0]       s_readdataid,
   output logic                  protocol_error
);

   localparam int MASK_W = DATA_W / 8;
   localparam int PTR_W  = $clog2(TAG_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   logic                 s_read_q, s_read_d;
   logic                 s_write_q, s_write_d;
   logic [ID_W-1:0]      s_id_q, s_id_d;
   logic [ADDR_W-1:0]    s_address_q, s_address_d;
   logic [DATA_W-1:0]    s_writedata_q, s_writedata_d;
   logic [MASK_W-1:0]    s_writedatamask_q, s_writedatamask_d;
   logic                 prio_q, prio_d;
   logic                 protocol_error_q, protocol_error_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [TAG_DEPTH-1:0] tag_q, tag_d;

   logic slot_free, fifo_full, fifo_empty;
   logic elig0, elig1, grant_valid, grant_m1;
   logic resp_valid, pop, push, head;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      slot_free         = !(s_read_q | s_write_q) | !s_waitrequest;
      fifo_full         = (count_q == CNT_W'(TAG_DEPTH));
      fifo_empty        = (count_q == '0);
      elig0             = (m0_read | m0_write) & (m0_write | !fifo_full);
      elig1             = (m1_read | m1_write) & (m1_write | !fifo_full);
      grant_valid       = slot_free & (elig0 | elig1);
      grant_m1          = elig1 & (!elig0 | prio_q);

      resp_valid        = (s_readdataid != '0);
      pop               = resp_valid & !fifo_empty;
      head              = tag_q[rd_ptr_q];

      s_read_d          = s_read_q;
      s_write_d         = s_write_q;
      s_id_d            = s_id_q;
      s_address_d       = s_address_q;
      s_writedata_d     = s_writedata_q;
      s_writedatamask_d = s_writedatamask_q;
      prio_d            = prio_q;
      push              = 1'b0;

      if (grant_valid) begin
         s_read_d          = grant_m1 ? m1_read          : m0_read;
         s_write_d         = grant_m1 ? m1_write         : m0_write;
         s_id_d            = grant_m1 ? m1_id            : m0_id;
         s_address_d       = grant_m1 ? m1_address       : m0_address;
         s_writedata_d     = grant_m1 ? m1_writedata     : m0_writedata;
         s_writedatamask_d = grant_m1 ? m1_writedatamask : m0_writedatamask;
         prio_d            = !grant_m1;
         push              = grant_m1 ? m1_read : m0_read;
      end else if (slot_free) begin
         // Slave took the previous request; drop the strobes but keep the payload stable.
         s_read_d  = 1'b0;
         s_write_d = 1'b0;
      end

      tag_d = tag_q;
      if (push) begin
         tag_d[wr_ptr_q] = grant_m1;
      end
      wr_ptr_d         = wr_ptr_q + PTR_W'(push);
      rd_ptr_d         = rd_ptr_q + PTR_W'(pop);
      count_d          = count_q + CNT_W'(push) - CNT_W'(pop);
      protocol_error_d = protocol_error_q | (resp_valid & fifo_empty);

      m0_waitrequest = !(grant_valid & !grant_m1);
      m1_waitrequest = !(grant_valid & grant_m1);
      m0_readdataid  = (pop && !head) ? s_readdataid : '0;
      m1_readdataid  = (pop &&  head) ? s_readdataid : '0;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         s_read_q          <= 1'b0;
         s_write_q         <= 1'b0;
         s_id_q            <= '0;
         s_address_q       <= '0;
         s_writedata_q     <= '0;
         s_writedatamask_q <= '0;
         prio_q            <= 1'b0;
         protocol_error_q  <= 1'b0;
         wr_ptr_q          <= '0;
         rd_ptr_q          <= '0;
         count_q           <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         s_read_q          <= s_read_d;
         s_write_q         <= s_write_d;
         s_id_q            <= s_id_d;
         s_address_q       <= s_address_d;
         s_writedata_q     <= s_writedata_d;
         s_writedatamask_q <= s_writedatamask_d;
         prio_q            <= prio_d;
         protocol_error_q  <= protocol_error_d;
         wr_ptr_q          <= wr_ptr_d;
         rd_ptr_q          <= rd_ptr_d;
         count_q           <= count_d;
      end
   end

   // NOTE: owner storage is deliberately not reset; count_q alone decides which entries are live.
   always_ff @(posedge clock) begin
      tag_q <= tag_d;
   end

   assign s_read          = s_read_q;
   assign s_write         = s_write_q;
   assign s_id            = s_id_q;
   assign s_address       = s_address_q;
   assign s_writedata     = s_writedata_q;
   assign s_writedatamask = s_writedatamask_q;
   assign protocol_error  = protocol_error_q;
   assign m0_readdata     = s_readdata;
   assign m1_readdata     = s_readdata;

endmodule
